// File: rtl/fp_mul_arbiter_pkg.sv
// Shared types and constants for the FPU multiplier arbiter slice.
package fp_mul_ctrl_pkg;

  localparam int unsigned FP_W = 32;
  localparam int unsigned RM_W = 3;

  localparam logic [RM_W-1:0] RM_RNE = 3'd0;
  localparam logic [RM_W-1:0] RM_RTZ = 3'd1;
  localparam logic [RM_W-1:0] RM_RDN = 3'd2;
  localparam logic [RM_W-1:0] RM_RUP = 3'd3;
  localparam logic [RM_W-1:0] RM_RMM = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier bus for the shared fp_mul arbiter.
interface fp_mul_arbiter_if
  import fp_mul_ctrl_pkg::*;
#(
  parameter int unsigned N = 2
);
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*FP_W-1:0] req_x;
  logic [N*FP_W-1:0] req_y;
  logic [N*RM_W-1:0] req_rmode;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [FP_W-1:0]   rsp_z;
  logic              rsp_ovrf;
  logic              rsp_udrf;
  logic [FP_W-1:0]   mul_fp_X;
  logic [FP_W-1:0]   mul_fp_Y;
  logic [RM_W-1:0]   mul_r_mode;
  logic [FP_W-1:0]   mul_fp_Z;
  logic              mul_ovrf;
  logic              mul_udrf;

  // Requesters plus the multiplier datapath, seen from outside the arbiter.
  modport master (
    output req_valid, req_x, req_y, req_rmode, rsp_ready,
           mul_fp_Z, mul_ovrf, mul_udrf,
    input  req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf,
           mul_fp_X, mul_fp_Y, mul_r_mode
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_x, req_y, req_rmode, rsp_ready,
           mul_fp_Z, mul_ovrf, mul_udrf,
    output req_ready, rsp_valid, rsp_z, rsp_ovrf, rsp_udrf,
           mul_fp_X, mul_fp_Y, mul_r_mode
  );
endinterface

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx
);
  logic        w_found;
  logic [31:0] w_pos;

  // Scan indices i_ptr, i_ptr+1, ... modulo N and latch the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = (32'(i_ptr) + k) % N;
      if (!w_found && i_req[w_pos[PTR_W-1:0]]) begin
        w_found                     = 1'b1;
        o_grant[w_pos[PTR_W-1:0]]   = 1'b1;
        o_idx                       = w_pos[PTR_W-1:0];
      end
    end
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one fp_mul datapath among N requesters,
// one operation in flight at a time.
module fp_mul_arbiter
  import fp_mul_ctrl_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned CNT_W   = $clog2(MUL_LAT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_mul_arbiter_if.slave bus,
  output logic           busy
);
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  if (MUL_LAT < 1) begin : g_lat_chk
    $error("fp_mul_arbiter: MUL_LAT must be at least 1");
  end

  state_t            r_state, w_next;
  logic [PTR_W-1:0]  r_ptr, r_owner, w_idx;
  logic [N-1:0]      w_grant;
  logic              w_any, w_last, w_rsp_hs;
  logic [CNT_W-1:0]  r_cnt;
  logic [FP_W-1:0]   r_mul_x, r_mul_y, r_z;
  logic [RM_W-1:0]   r_mul_rm;
  logic              r_ovrf, r_udrf;
  logic [FP_W-1:0]   w_x [N];
  logic [FP_W-1:0]   w_y [N];
  logic [RM_W-1:0]   w_rm [N];

  rr_arbiter #(.N(N), .PTR_W(PTR_W)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_any    = |w_grant;
  assign w_last   = (r_cnt == CNT_W'(1));
  assign w_rsp_hs = bus.rsp_ready[r_owner];

  // Unpack the flat per-requester operand buses.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_x[i]  = bus.req_x[i*FP_W +: FP_W];
      w_y[i]  = bus.req_y[i*FP_W +: FP_W];
      w_rm[i] = bus.req_rmode[i*RM_W +: RM_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any)    w_next = BUSY;
      BUSY:    if (w_last)   w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, latency count, result capture and pointer advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_mul_x  <= '0;
      r_mul_y  <= '0;
      r_mul_rm <= '0;
      r_z      <= '0;
      r_ovrf   <= 1'b0;
      r_udrf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_mul_x  <= w_x[w_idx];
          r_mul_y  <= w_y[w_idx];
          r_mul_rm <= w_rm[w_idx];
          r_owner  <= w_idx;
          r_cnt    <= CNT_W'(MUL_LAT);
        end
        BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_z    <= bus.mul_fp_Z;
            r_ovrf <= bus.mul_ovrf;
            r_udrf <= bus.mul_udrf;
          end
        end
        RESP: if (w_rsp_hs) begin
          r_ptr <= (r_owner == PTR_W'(N - 1)) ? '0 : r_owner + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    busy          = 1'b0;
    case (r_state)
      IDLE: bus.req_ready = w_grant;
      BUSY: busy = 1'b1;
      RESP: begin
        busy                   = 1'b1;
        bus.rsp_valid[r_owner] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mul_fp_X   = r_mul_x;
  assign bus.mul_fp_Y   = r_mul_y;
  assign bus.mul_r_mode = r_mul_rm;
  assign bus.rsp_z      = r_z;
  assign bus.rsp_ovrf   = r_ovrf;
  assign bus.rsp_udrf   = r_udrf;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: one instance with MUL_LAT=1, one with MUL_LAT=3.
module tb_fp_mul_arbiter;
  import fp_mul_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, busy3;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter_if #(.N(2)) if1 ();
  fp_mul_arbiter_if #(.N(2)) if3 ();

  fp_mul_arbiter #(.N(2), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1));
  fp_mul_arbiter #(.N(2), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .busy(busy3));

  // Stand-in multiplier: known products for the directed vectors, X^Y otherwise.
  function automatic logic [33:0] mul_model(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h3FC00000 && y == 32'h40000000) return {32'h40400000, 1'b0, 1'b0};
    if (x == 32'h00000001 && y == 32'h3F800000) return {32'h00000000, 1'b0, 1'b1};
    if (x == 32'h7F000000 && y == 32'h7F000000) return {32'h7F800000, 1'b1, 1'b0};
    return {x ^ y, 1'b0, 1'b0};
  endfunction

  always_comb {if1.mul_fp_Z, if1.mul_ovrf, if1.mul_udrf} = mul_model(if1.mul_fp_X, if1.mul_fp_Y);
  always_comb {if3.mul_fp_Z, if3.mul_ovrf, if3.mul_udrf} = mul_model(if3.mul_fp_X, if3.mul_fp_Y);

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy1); end
    n_vec++; if (if1.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b exp 00", if1.req_ready); end
    n_vec++; if (if1.rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 00", if1.rsp_valid); end
    n_vec++; if ({if1.mul_fp_X, if1.mul_fp_Y, if1.mul_r_mode} !== 67'd0) begin n_err++; $display("FAIL reset_mul_ops got %h %h %h exp 0", if1.mul_fp_X, if1.mul_fp_Y, if1.mul_r_mode); end
    n_vec++; if ({if1.rsp_z, if1.rsp_ovrf, if1.rsp_udrf} !== 34'd0) begin n_err++; $display("FAIL reset_rsp got %h %b %b exp 0", if1.rsp_z, if1.rsp_ovrf, if1.rsp_udrf); end
    n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL reset_busy3 got %b exp 0", busy3); end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    if1.req_x[31:0] = 32'h3FC00000; if1.req_y[31:0] = 32'h40000000;
    if1.req_rmode[2:0] = RM_RNE; if1.req_valid = 2'b01; if1.rsp_ready = 2'b00;
    @(negedge clk);
    n_vec++; if (if1.req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b exp 01", if1.req_ready); end
    @(posedge clk); #1 if1.req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (if1.rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early_valid got %b exp 00", if1.rsp_valid); end
    n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", busy1); end
    n_vec++; if (if1.mul_fp_X !== 32'h3FC00000) begin n_err++; $display("FAIL single_opx got %h exp 3fc00000", if1.mul_fp_X); end
    @(negedge clk);
    n_vec++; if (if1.rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid got %b exp 01", if1.rsp_valid); end
    n_vec++; if (if1.rsp_z !== 32'h40400000) begin n_err++; $display("FAIL single_z got %h exp 40400000", if1.rsp_z); end
    n_vec++; if ({if1.rsp_ovrf, if1.rsp_udrf} !== 2'b00) begin n_err++; $display("FAIL single_flags got %b%b exp 00", if1.rsp_ovrf, if1.rsp_udrf); end
    if1.rsp_ready = 2'b01;
    @(posedge clk); #1 if1.rsp_ready = 2'b00;
    @(negedge clk);
    n_vec++; if ({busy1, if1.rsp_valid} !== 3'b000) begin n_err++; $display("FAIL single_done got busy=%b valid=%b exp 0 00", busy1, if1.rsp_valid); end
  endtask

  task automatic test_subnormal();
    logic [30:0] zlow;
    @(posedge clk); #1;
    if1.req_x[63:32] = 32'h00000001; if1.req_y[63:32] = 32'h3F800000;
    if1.req_rmode[5:3] = RM_RNE; if1.req_valid = 2'b10;
    @(negedge clk);
    n_vec++; if (if1.req_ready !== 2'b10) begin n_err++; $display("FAIL sub_ready got %b exp 10", if1.req_ready); end
    @(posedge clk); #1 if1.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    zlow = if1.rsp_z[30:0];
    n_vec++; if (if1.rsp_valid !== 2'b10) begin n_err++; $display("FAIL sub_rsp_valid got %b exp 10", if1.rsp_valid); end
    n_vec++; if (zlow !== 31'd0) begin n_err++; $display("FAIL sub_z got %h exp 0", zlow); end
    n_vec++; if (if1.rsp_udrf !== 1'b1) begin n_err++; $display("FAIL sub_udrf got %b exp 1", if1.rsp_udrf); end
    if1.rsp_ready = 2'b10;
    @(posedge clk); #1 if1.rsp_ready = 2'b00;
  endtask

  task automatic test_overflow_backpressure();
    @(posedge clk); #1;
    if1.req_x[31:0] = 32'h7F000000; if1.req_y[31:0] = 32'h7F000000;
    if1.req_rmode[2:0] = RM_RNE; if1.req_valid = 2'b01; if1.rsp_ready = 2'b00;
    @(negedge clk);
    n_vec++; if (if1.req_ready !== 2'b01) begin n_err++; $display("FAIL ovf_ready got %b exp 01", if1.req_ready); end
    @(posedge clk); #1;
    if1.req_x[63:32] = 32'h12345678; if1.req_y[63:32] = 32'h0F0F0F0F;
    if1.req_rmode[5:3] = 3'd7; if1.req_valid = 2'b10; if1.rsp_ready = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (if1.rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_valid cyc %0d got %b exp 01", i, if1.rsp_valid); end
      n_vec++; if ({if1.rsp_z, if1.rsp_ovrf, if1.rsp_udrf} !== {32'h7F800000, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL bp_result cyc %0d got %h %b %b exp 7f800000 1 0", i, if1.rsp_z, if1.rsp_ovrf, if1.rsp_udrf); end
      n_vec++; if (if1.req_ready !== 2'b00) begin n_err++; $display("FAIL bp_no_grant cyc %0d got %b exp 00", i, if1.req_ready); end
      n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL bp_busy cyc %0d got %b exp 1", i, busy1); end
    end
    if1.rsp_ready = 2'b01;
    @(posedge clk); #1 if1.rsp_ready = 2'b00;
    @(negedge clk);
    n_vec++; if (if1.rsp_valid !== 2'b00) begin n_err++; $display("FAIL bp_release got %b exp 00", if1.rsp_valid); end
    n_vec++; if (if1.req_ready !== 2'b10) begin n_err++; $display("FAIL bp_next_grant got %b exp 10", if1.req_ready); end
    @(posedge clk); #1 if1.req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (if1.mul_r_mode !== 3'd7) begin n_err++; $display("FAIL rmode7_fwd got %0d exp 7", if1.mul_r_mode); end
    @(negedge clk);
    n_vec++; if (if1.rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_r1_valid got %b exp 10", if1.rsp_valid); end
    n_vec++; if (if1.rsp_z !== 32'h1D3B5977) begin n_err++; $display("FAIL bp_r1_z got %h exp 1d3b5977", if1.rsp_z); end
    if1.rsp_ready = 2'b10;
    @(posedge clk); #1 if1.rsp_ready = 2'b00;
  endtask

  task automatic test_contention();
    int cyc;
    logic [1:0] rdy, exp_oh;
    logic [31:0] exp_z;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    if1.req_x = {32'hB0000002, 32'hA0000001};
    if1.req_y = {32'h000000F0, 32'h0000000F};
    if1.req_rmode = {RM_RDN, RM_RTZ};
    if1.rsp_ready = 2'b11; if1.req_valid = 2'b11;
    for (int op = 0; op < 4; op++) begin
      exp_oh = (op % 2 == 0) ? 2'b01 : 2'b10;
      exp_z  = (op % 2 == 0) ? 32'hA000000E : 32'hB00000F2;
      cyc = 0; rdy = 2'b00;
      while (rdy == 2'b00 && cyc < 10) begin
        @(negedge clk); cyc++; rdy = if1.req_ready;
        n_vec++; if ($countones(if1.req_ready) > 1) begin n_err++; $display("FAIL cont_onehot got %b exp at most one bit", if1.req_ready); end
      end
      n_vec++; if (rdy !== exp_oh) begin n_err++; $display("FAIL cont_grant op %0d got %b exp %b", op, rdy, exp_oh); end
      cyc = 0;
      while (if1.rsp_valid == 2'b00 && cyc < 10) begin @(negedge clk); cyc++; end
      n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL cont_latency op %0d got %0d exp 2", op, cyc); end
      n_vec++; if (if1.rsp_valid !== exp_oh) begin n_err++; $display("FAIL cont_rsp_valid op %0d got %b exp %b", op, if1.rsp_valid, exp_oh); end
      n_vec++; if (if1.rsp_z !== exp_z) begin n_err++; $display("FAIL cont_z op %0d got %h exp %h", op, if1.rsp_z, exp_z); end
    end
    if1.req_valid = 2'b00;
    @(posedge clk); #1 if1.rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    logic seen;
    @(posedge clk); #1;
    if3.req_x[31:0] = 32'h00000003; if3.req_y[31:0] = 32'h00000005;
    if3.req_rmode[2:0] = RM_RUP; if3.req_valid = 2'b01; if3.rsp_ready = 2'b01;
    @(negedge clk);
    n_vec++; if (if3.req_ready !== 2'b01) begin n_err++; $display("FAIL l3_ready got %b exp 01", if3.req_ready); end
    @(posedge clk); #1 if3.req_valid = 2'b00;
    cyc = 1;
    @(negedge clk);
    while (if3.rsp_valid == 2'b00 && cyc < 12) begin @(negedge clk); cyc++; end
    n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL l3_latency got %0d exp 4", cyc); end
    n_vec++; if ({if3.rsp_valid, if3.rsp_z} !== {2'b01, 32'h00000006}) begin n_err++; $display("FAIL l3_rsp got %b %h exp 01 00000006", if3.rsp_valid, if3.rsp_z); end
    @(posedge clk); #1;
    if3.req_x[63:32] = 32'h40490FDB; if3.req_y[63:32] = 32'h3F000000;
    if3.req_rmode[5:3] = 3'd6; if3.req_valid = 2'b10; if3.rsp_ready = 2'b00;
    @(negedge clk);
    n_vec++; if (if3.req_ready !== 2'b10) begin n_err++; $display("FAIL l3_ptr_adv got %b exp 10", if3.req_ready); end
    @(posedge clk); #1 if3.req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if ({busy3, if3.mul_fp_X, if3.mul_r_mode} !== {1'b1, 32'h40490FDB, 3'd6}) begin
      n_err++; $display("FAIL l3_busy_ops got %b %h %0d exp 1 40490fdb 6", busy3, if3.mul_fp_X, if3.mul_r_mode); end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (busy3 !== 1'b1) begin n_err++; $display("FAIL l3_busy2 got %b exp 1", busy3); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({busy3, if3.req_ready, if3.rsp_valid} !== 5'd0) begin n_err++; $display("FAIL rst_mid_ctrl got %b %b %b exp 0", busy3, if3.req_ready, if3.rsp_valid); end
    n_vec++; if ({if3.mul_fp_X, if3.mul_fp_Y, if3.mul_r_mode} !== 67'd0) begin n_err++; $display("FAIL rst_mid_mul got %h %h %0d exp 0", if3.mul_fp_X, if3.mul_fp_Y, if3.mul_r_mode); end
    n_vec++; if ({if3.rsp_z, if3.rsp_ovrf, if3.rsp_udrf} !== 34'd0) begin n_err++; $display("FAIL rst_mid_rsp got %h %b %b exp 0", if3.rsp_z, if3.rsp_ovrf, if3.rsp_udrf); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if3.rsp_valid != 2'b00) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_rsp got 1 exp 0"); end
    @(posedge clk); #1 if3.req_valid = 2'b11;
    @(negedge clk);
    n_vec++; if (if3.req_ready !== 2'b01) begin n_err++; $display("FAIL rst_mid_ptr got %b exp 01", if3.req_ready); end
    @(posedge clk); #1 if3.req_valid = 2'b00;
  endtask

  initial begin
    if1.req_valid = '0; if1.req_x = '0; if1.req_y = '0; if1.req_rmode = '0; if1.rsp_ready = '0;
    if3.req_valid = '0; if3.req_x = '0; if3.req_y = '0; if3.req_rmode = '0; if3.rsp_ready = '0;
    test_reset();
    test_single();
    test_subnormal();
    test_overflow_backpressure();
    test_contention();
    test_reset_mid_busy();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one fp_mul datapath (fp_X/fp_Y/r_mode in; fp_Z/ovrf/udrf out) among N requesters.
- Uses round-robin arbitration, holds the multiplier operands stable for a fixed latency, registers the result, and returns it to the owning requester over a valid/ready handshake.
- Sits between the FPU issue logic and the multiplier. Only one operation is in flight at a time.

Parameters:
- N, 2, number of requesters (≥2).
- MUL_LAT, 1, cycles from operand drive to result sample (≥1; 0 is illegal and must trip an elaboration assert).
- CNT_W, $clog2(MUL_LAT+1), latency counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N  request valid, one bit per requester.
- req_ready  out  N  request accepted; at most one bit set.
- req_x  in  N*32  operand X, requester i at bits [32i+31:32i].
- req_y  in  N*32  operand Y, same packing.
- req_rmode  in  N*3  rounding mode, same packing.
- rsp_valid  out  N  result valid for owner i.
- rsp_ready  in  N  owner accepts result.
- rsp_z  out  32  result (shared bus).
- rsp_ovrf  out  1  overflow flag.
- rsp_udrf  out  1  underflow flag.
- mul_fp_X  out  32  to multiplier.
- mul_fp_Y  out  32  to multiplier.
- mul_r_mode  out  3  to multiplier.
- mul_fp_Z  in  32  from multiplier.
- mul_ovrf  in  1  from multiplier.
- mul_udrf  in  1  from multiplier.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n low at posedge):
  - state=IDLE, rr_ptr=0, owner=0, cnt=0.
  - mul_fp_X, mul_fp_Y, rsp_z = 0; mul_r_mode=0; rsp_ovrf/rsp_udrf=0.
  - req_ready=0, rsp_valid=0, busy=0.
  - Reset mid-operation abandons the op silently; no response is ever issued for it.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid is set, grant g = first valid index searching rr_ptr, rr_ptr+1, … mod N.
  - req_ready[g]=1 combinationally in that cycle; all other ready bits are 0. req_ready is 0 in BUSY/RESP.
  - At the clock edge: capture req_x[g], req_y[g], req_rmode[g] into mul_fp_X, mul_fp_Y, mul_r_mode; set owner=g, cnt=MUL_LAT, state=BUSY.
  - If no req_valid is set, remain in IDLE; mul_* keep their last values.
- BUSY:
  - mul_* held constant.
  - cnt decrements each cycle.
  - In the cycle cnt==1: register mul_fp_Z, mul_ovrf, mul_udrf into rsp_z, rsp_ovrf, rsp_udrf; state=RESP.
  - Result is therefore sampled exactly MUL_LAT cycles after the grant edge.
- RESP:
  - rsp_valid[owner]=1; all other rsp_valid bits are 0.
  - rsp_z and flags stay stable until handshake.
  - On rsp_ready[owner]: rr_ptr=(owner+1) mod N (wrap N-1→0), state=IDLE.
  - rsp_ready of non-owners is ignored.
  - A new request is not granted in the same cycle as the response handshake.
- Throughput: one op per MUL_LAT+2 cycles minimum. Grant-to-rsp_valid latency = MUL_LAT+1 cycles.
- r_mode values 5–7 are forwarded unchanged. The datapath defines the result; the arbiter does not check it.
- The arbiter never alters operand or result bits: a subnormal-operand zeroing or an overflow is exactly what the multiplier produced.
- Fairness: a continuously valid requester is granted within N ops.
- Requesters may deassert req_valid before grant without penalty. Operands are sampled only at the grant edge.

Decomposition:
- fp_mul_ctrl_pkg:
  - state_t enum {IDLE, BUSY, RESP}.
  - FP_W=32, RM_W=3.
  - Rounding-mode constants RM_RNE=0, RM_RTZ=1, RM_RDN=2, RM_RUP=3, RM_RMM=4.
- Sub-module rr_arbiter:
  - Parameterised by N.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and grant index.
  - Purely combinational, reused by other FPU unit arbiters.

Test Plan:
- Single op, requester 0, X=0x3FC00000, Y=0x40000000, rmode=0, MUL_LAT=1 → req_ready[0] high in request cycle; rsp_valid[0] two cycles later with rsp_z=0x40400000, ovrf=0, udrf=0.
- Subnormal operand, requester 1, X=0x00000001, Y=0x3F800000 → rsp_valid[1] with rsp_z[30:0]=0; rsp_valid[0] stays 0.
- Overflow: X=Y=0x7F000000, rmode=0 → rsp_ovrf=1 and rsp_z equal to the multiplier output (0x7F800000), held stable across the response.
- Contention: both requesters valid continuously for 4 ops from reset → grant order 0, 1, 0, 1; never two ready bits set at once.
- Backpressure: rsp_ready[owner]=0 for 5 cycles → rsp_valid, rsp_z and flags unchanged; no req_ready asserted; busy=1 throughout.
- Reset mid-BUSY (MUL_LAT=3, rst_n low at second BUSY cycle) → next cycle all outputs zero, state IDLE, rr_ptr=0, and no rsp_valid for the abandoned op.
